axil_reg_bridge: RTL and testbench

AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

---
 rtl/axil_reg_bridge.sv | 182 ++++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave to single-outstanding register bus; AXIL_REG_BRIDGE_TIMEOUT_EN adds a reg_ack timeout.
module axil_reg_bridge #(
  parameter int AXI_AWIDTH     = 12,
  parameter int AXI_DWIDTH     = 32,
  parameter int ADDR_LIMIT     = 4096,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AXI_AWIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  input  logic [2:0]              AWPROT,
  output logic                    AWREADY,
  input  logic [AXI_DWIDTH-1:0]   WDATA,
  input  logic [AXI_DWIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [AXI_AWIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  input  logic [2:0]              ARPROT,
  output logic                    ARREADY,
  output logic [AXI_DWIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    reg_req,
  output logic                    reg_we,
  output logic [AXI_AWIDTH-1:0]   reg_addr,
  output logic [AXI_DWIDTH-1:0]   reg_wdata,
  output logic [AXI_DWIDTH/8-1:0] reg_wstrb,
  input  logic                    reg_ack,
  input  logic [AXI_DWIDTH-1:0]   reg_rdata
);
  localparam int SW = AXI_DWIDTH / 8;
  localparam logic [AXI_AWIDTH-1:0] AMASK = ~AXI_AWIDTH'(SW - 1);
  // limit clamped to the address space so the compare never truncates
  localparam logic [AXI_AWIDTH:0] LIMIT = (ADDR_LIMIT >= (1 << AXI_AWIDTH)) ?
    (AXI_AWIDTH+1)'(1 << AXI_AWIDTH) : (AXI_AWIDTH+1)'(ADDR_LIMIT);
  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;
  state_t                  r_state, w_state;
  logic                    r_awready, w_awready, r_arready, w_arready;
  logic                    r_bvalid, w_bvalid, r_rvalid, w_rvalid;
  logic [1:0]              r_bresp, w_bresp, r_rresp, w_rresp;
  logic [AXI_DWIDTH-1:0]   r_rdata, w_rdata, r_wdata, w_wdata;
  logic                    r_req, w_req, r_we, w_we, r_last_wr, w_last_wr;
  logic [AXI_AWIDTH-1:0]   r_addr, w_addr;
  logic [SW-1:0]           r_wstrb, w_wstrb;
  logic                    w_aw_ok, w_ar_ok, w_to, w_unused;
  assign w_aw_ok = {1'b0, AWADDR} < LIMIT;
  assign w_ar_ok = {1'b0, ARADDR} < LIMIT;
`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
  logic [15:0] r_cnt;
  assign w_to = r_cnt == 16'(TIMEOUT_CYCLES - 1);
  assign w_unused = ^{AWPROT, ARPROT};
  always_ff @(posedge clk)
    if (reset || w_state != r_state || (r_state != WR_REQ && r_state != RD_REQ)) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
`else
  assign w_to = 1'b0;
  assign w_unused = ^{AWPROT, ARPROT, 16'(TIMEOUT_CYCLES)};
`endif
  always_comb begin
    w_state   = r_state;
    w_awready = 1'b0;
    w_arready = 1'b0;
    w_bvalid  = r_bvalid;
    w_bresp   = r_bresp;
    w_rvalid  = r_rvalid;
    w_rresp   = r_rresp;
    w_rdata   = r_rdata;
    w_req     = r_req;
    w_we      = r_we;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_wstrb   = r_wstrb;
    w_last_wr = r_last_wr;
    case (r_state)
      IDLE:
        if (r_awready && AWVALID && WVALID) begin
          w_we     = 1'b1;
          w_addr   = AWADDR & AMASK;
          w_wdata  = WDATA;
          w_wstrb  = WSTRB;
          w_req    = w_aw_ok;
          w_state  = w_aw_ok ? WR_REQ : WR_RESP;
          w_bvalid = !w_aw_ok;
          w_bresp  = w_aw_ok ? 2'b00 : 2'b10;
        end else if (r_arready && ARVALID) begin
          w_we     = 1'b0;
          w_addr   = ARADDR & AMASK;
          w_req    = w_ar_ok;
          w_state  = w_ar_ok ? RD_REQ : RD_RESP;
          w_rvalid = !w_ar_ok;
          w_rresp  = w_ar_ok ? 2'b00 : 2'b10;
          w_rdata  = '0;
        end else if (!r_awready && !r_arready) begin
          // round-robin: a read beats a write only when the last grant was a write
          if (AWVALID && WVALID && !(ARVALID && r_last_wr)) begin
            w_awready = 1'b1;
            w_last_wr = 1'b1;
          end else if (ARVALID) begin
            w_arready = 1'b1;
            w_last_wr = 1'b0;
          end
        end
      WR_REQ:
        if (reg_ack || w_to) begin
          w_req    = 1'b0;
          w_state  = WR_RESP;
          w_bvalid = 1'b1;
          w_bresp  = reg_ack ? 2'b00 : 2'b10;
        end
      RD_REQ:
        if (reg_ack || w_to) begin
          w_req    = 1'b0;
          w_state  = RD_RESP;
          w_rvalid = 1'b1;
          w_rresp  = reg_ack ? 2'b00 : 2'b10;
          w_rdata  = reg_ack ? reg_rdata : '0;
        end
      WR_RESP:
        if (BREADY) begin
          w_bvalid = 1'b0;
          w_state  = IDLE;
        end
      RD_RESP:
        if (RREADY) begin
          w_rvalid = 1'b0;
          w_state  = IDLE;
        end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_last_wr <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_awready <= w_awready;
      r_arready <= w_arready;
      r_bvalid  <= w_bvalid;
      r_bresp   <= w_bresp;
      r_rvalid  <= w_rvalid;
      r_rresp   <= w_rresp;
      r_rdata   <= w_rdata;
      r_req     <= w_req;
      r_we      <= w_we;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_wstrb   <= w_wstrb;
      r_last_wr <= w_last_wr;
    end
  assign AWREADY   = r_awready;
  assign WREADY    = r_awready;
  assign ARREADY   = r_arready;
  assign BVALID    = r_bvalid;
  assign BRESP     = r_bresp;
  assign RVALID    = r_rvalid;
  assign RRESP     = r_rresp;
  assign RDATA     = r_rdata;
  assign reg_req   = r_req;
  assign reg_we    = r_we;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wstrb = r_wstrb;
endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb_axil_reg_bridge: directed bench with a transaction-level model checked every cycle.
module tb_axil_reg_bridge;
  localparam int AW = 12, DW = 32, LIM = 'h800, TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0, reg_addr;
  logic AWVALID = 0, WVALID = 0, ARVALID = 0, BREADY = 1, RREADY = 1;
  logic [2:0] AWPROT = 3'd0, ARPROT = 3'd0;
  logic [DW-1:0] WDATA = '0, RDATA, reg_wdata, reg_rdata = '0;
  logic [DW/8-1:0] WSTRB = '0, reg_wstrb;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID, reg_req, reg_we, reg_ack;
  logic [1:0] BRESP, RRESP;
  logic tb_ack = 0, auto_ack = 0, started = 0;
  assign reg_ack = tb_ack | (auto_ack & reg_req);

  axil_reg_bridge #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .ADDR_LIMIT(LIM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata));

  int vectors = 0, miscompares = 0, req_cycles = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction model: one outstanding access, request phase then response phase
  bit m_req = 0, m_resp = 0, m_is_wr = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic [1:0] m_code;
  int m_cnt;
  bit grants[$];
  task automatic accept(input bit wr, input logic [AW-1:0] a);
    grants.push_back(wr);
    m_is_wr = wr;
    if (int'(a) < LIM) begin
      m_req = 1; m_cnt = 0; m_addr = a & ~12'h3; m_wdata = WDATA; m_wstrb = WSTRB;
    end else begin
      m_resp = 1; m_code = 2'b10; m_rdata = '0;
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_resp = 0;
    end else begin
      bit idle;
      idle = !m_req && !m_resp;
      if (m_resp && (m_is_wr ? BREADY : RREADY)) m_resp = 0;
      if (m_req) begin
        m_cnt++;
        if (reg_ack) begin
          m_req = 0; m_resp = 1; m_code = 2'b00; m_rdata = reg_rdata;
        end
`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
        else if (m_cnt == TO) begin
          m_req = 0; m_resp = 1; m_code = 2'b10; m_rdata = '0;
        end
`endif
      end
      if (idle && AWVALID && WVALID && AWREADY && WREADY) accept(1, AWADDR);
      else if (idle && ARVALID && ARREADY) accept(0, ARADDR);
    end
  end

  always @(negedge clk) if (started && !reset) begin
    chk("reg_req", reg_req, m_req);
    if (m_req) begin
      chk("reg_addr", reg_addr, m_addr);
      chk("reg_we", reg_we, m_is_wr);
      if (m_is_wr) begin
        chk("reg_wdata", reg_wdata, m_wdata);
        chk("reg_wstrb", reg_wstrb, m_wstrb);
      end
    end
    chk("bvalid", BVALID, m_resp && m_is_wr);
    if (BVALID && m_resp && m_is_wr) chk("bresp", BRESP, m_code);
    chk("rvalid", RVALID, m_resp && !m_is_wr);
    if (RVALID && m_resp && !m_is_wr) begin
      chk("rresp", RRESP, m_code);
      chk("rdata", RDATA, m_rdata);
    end
    chk("awready_wready", AWREADY, WREADY);
    if (m_req || m_resp) chk("ready_busy", AWREADY | ARREADY, 0);
    if (reg_req) req_cycles++;
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic send_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    bit ok = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (AWREADY) begin ok = 1; break; end end
    if (!ok) chk("aw_handshake_wait", 0, 1);
    tick; AWVALID = 0; WVALID = 0;
  endtask
  task automatic send_r(input logic [AW-1:0] a);
    bit ok = 0;
    ARADDR = a; ARVALID = 1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (ARREADY) begin ok = 1; break; end end
    if (!ok) chk("ar_handshake_wait", 0, 1);
    tick; ARVALID = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c0, rv;
    repeat (3) tick;
    reset = 0;
    @(negedge clk);
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 0);
    chk("rst_valid", {BVALID, RVALID, reg_req}, 0);
    chk("rst_resp", {BRESP, RRESP}, 0);
    chk("rst_rdata", RDATA, 0);
    started = 1;
    tick;
    // write with same-cycle ack
    send_w(12'h010, 32'hDEADBEEF, 4'hF);
    tb_ack = 1;
    @(negedge clk);
    chk("wr_req_n1", reg_req, 1);
    chk("wr_wdata", reg_wdata, 32'hDEADBEEF);
    chk("wr_addr", reg_addr, 12'h010);
    tick; tb_ack = 0;
    @(negedge clk);
    chk("wr_bvalid_n2", BVALID, 1);
    chk("wr_bresp", BRESP, 2'b00);
    tick;
    @(negedge clk);
    chk("wr_bvalid_clr", BVALID, 0);
    tick;
    // read with ack after 3 wait cycles and held response
    RREADY = 0;
    send_r(12'h013);
    repeat (3) tick;
    tb_ack = 1; reg_rdata = 32'h12345678;
    @(negedge clk);
    chk("rd_req", reg_req, 1);
    chk("rd_addr", reg_addr, 12'h010);
    tick; tb_ack = 0; reg_rdata = 32'hAAAAAAAA;
    @(negedge clk);
    chk("rd_rvalid", RVALID, 1);
    chk("rd_rdata", RDATA, 32'h12345678);
    chk("rd_rresp", RRESP, 2'b00);
    tick;
    @(negedge clk);
    chk("rd_hold", {RVALID, RDATA}, {1'b1, 32'h12345678});
    RREADY = 1;
    tick;
    @(negedge clk);
    chk("rd_rvalid_clr", RVALID, 0);
    tick;
    // out-of-range read
    c0 = req_cycles;
    send_r(12'hFFC);
    @(negedge clk);
    chk("oob_rvalid", RVALID, 1);
    chk("oob_rresp", RRESP, 2'b10);
    chk("oob_rdata", RDATA, 0);
    repeat (2) tick;
    chk("oob_no_req", req_cycles, c0);
    // last in-range byte with zero strobe, then first out-of-range address
    send_w(12'h7FF, 32'h0BADF00D, 4'h0);
    tb_ack = 1;
    @(negedge clk);
    chk("edge_addr", reg_addr, 12'h7FC);
    chk("edge_wstrb", reg_wstrb, 4'h0);
    tick; tb_ack = 0;
    @(negedge clk);
    chk("edge_bresp", {BVALID, BRESP}, {1'b1, 2'b00});
    tick;
    send_w(12'h800, 32'h11111111, 4'hF);
    @(negedge clk);
    chk("lim_bresp", {BVALID, BRESP, reg_req}, {1'b1, 2'b10, 1'b0});
    repeat (2) tick;
    // no ack at all
    send_w(12'h020, 32'h55AA55AA, 4'h3);
    n = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (!reg_req) break; n++; end
`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
    chk("to_req_cycles", n, TO);
    chk("to_bresp", {BVALID, BRESP}, {1'b1, 2'b10});
`else
    chk("noto_still_waiting", n, 30);
    tb_ack = 1;
    tick; tb_ack = 0;
    @(negedge clk);
    chk("noto_bresp", {BVALID, BRESP}, {1'b1, 2'b00});
`endif
    repeat (2) tick;
    // reset while in RD_REQ, then a stray ack
    send_r(12'h100);
    @(negedge clk);
    chk("rst_inflight_req", reg_req, 1);
    reset = 1;
    tick; reset = 0;
    @(negedge clk);
    chk("rst_inflight_clr", {AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_req}, 0);
    tb_ack = 1;
    tick; tb_ack = 0;
    rv = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); rv += int'(RVALID); end
    chk("rst_no_rvalid", rv, 0);
    // simultaneous write and read, twice
    grants.delete();
    auto_ack = 1;
    for (int r = 0; r < 2; r++) begin
      bit ok = 0;
      AWADDR = 12'h040; WDATA = 32'hCAFE0000 + r; WSTRB = 4'hF; ARADDR = 12'h044;
      AWVALID = 1; WVALID = 1; ARVALID = 1;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (AWREADY || ARREADY) begin ok = 1; break; end end
      chk("arb_grant_seen", ok, 1);
      chk("arb_grant", {AWREADY, ARREADY}, r == 0 ? 2'b10 : 2'b01);
      tick; AWVALID = 0; WVALID = 0; ARVALID = 0;
      repeat (5) tick;
    end
    auto_ack = 0;
    chk("arb_count", grants.size(), 2);
    if (grants.size() == 2) chk("arb_order", {grants[0], grants[1]}, 2'b10);
    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
